seq_detector_multi: RTL and testbench

SEQ_DETECTOR_MULTI -- requirements
Module: seq_detector_multi

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_det_match.sv | 17 +
 rtl/seq_detector_multi.sv | 144 ++++++++++++++
 tb/tb_seq_detector_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the multi-pattern serial sequence detector:
// FSM state encoding and default sizing.
package seq_det_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SEARCH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_det_match.sv
// Single pattern slot comparator: hit when enabled and every cared-about bit
// of the window equals the stored pattern.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] window,
    input  logic [W-1:0] pattern,
    input  logic [W-1:0] mask,
    input  logic         en,
    output logic         hit
);

    assign hit = en && (((window ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_detector_multi.sv
// Serial bit-stream detector matching N programmable W-bit patterns.
// Define SEQ_DET_MASK_EN to add a per-slot don't-care mask (cfg_mask).
module seq_detector_multi
    import seq_det_pkg::*;
#(
    parameter int  W     = DEF_W,
    parameter int  N     = DEF_N,
    parameter int  CNT_W = DEF_CNT_W,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [W-1:0]     cfg_pattern,
    input  logic             cfg_en,
`ifdef SEQ_DET_MASK_EN
    input  logic [W-1:0]     cfg_mask,
`endif
    input  logic             start,
    input  logic             stop,
    input  logic             overlap,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             found,
    output logic [N-1:0]     found_vec,
    output logic [IW-1:0]    found_id,
    output logic [CNT_W-1:0] match_count
);

    localparam int FW = $clog2(W + 1);

    state_t         state;
    logic [W-1:0]   window;
    logic [W-1:0]   next_window;
    logic [FW-1:0]  fill_cnt;
    logic [W-1:0]   pat_mem [N];
    logic [N-1:0]   en_mem;
`ifdef SEQ_DET_MASK_EN
    logic [W-1:0]   mask_mem [N];
`endif
    logic [N-1:0]   hit_vec;
    logic [IW-1:0]  low_id;
    logic           accept;
    logic           eval;
    logic           event_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign next_window = {window[W-2:0], bit_in};
    assign accept      = bit_valid && (state != ST_IDLE);
    // Compare only once the bit being accepted completes a full window.
    assign eval        = accept && ((state == ST_SEARCH) || (fill_cnt == FW'(W - 1)));
    assign event_hit   = eval && (hit_vec != '0);
    assign busy        = (state != ST_IDLE);

    for (genvar k = 0; k < N; k++) begin : g_slot
        seq_det_match #(.W(W)) u_match (
            .window  (next_window),
            .pattern (pat_mem[k]),
`ifdef SEQ_DET_MASK_EN
            .mask    (mask_mem[k]),
`else
            .mask    ({W{1'b1}}),
`endif
            .en      (en_mem[k]),
            .hit     (hit_vec[k])
        );
    end

    always_comb begin
        low_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit_vec[k]) low_id = IW'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            window      <= '0;
            fill_cnt    <= '0;
            en_mem      <= '0;
            found       <= 1'b0;
            found_vec   <= '0;
            found_id    <= '0;
            match_count <= '0;
            for (int k = 0; k < N; k++) begin
                pat_mem[k]  <= '0;
`ifdef SEQ_DET_MASK_EN
                mask_mem[k] <= '0;
`endif
            end
        end else begin
            if (cfg_we && (int'(cfg_idx) < N)) begin
                pat_mem[cfg_idx]  <= cfg_pattern;
                en_mem[cfg_idx]   <= cfg_en;
`ifdef SEQ_DET_MASK_EN
                mask_mem[cfg_idx] <= cfg_mask;
`endif
            end

            found     <= 1'b0;
            found_vec <= '0;
            found_id  <= '0;

            if (start) begin
                state       <= ST_FILL;
                window      <= '0;
                fill_cnt    <= '0;
                match_count <= '0;
            end else if (stop) begin
                state <= ST_IDLE;
            end else if (accept) begin
                window <= next_window;
                if (event_hit) begin
                    found       <= 1'b1;
                    found_vec   <= hit_vec;
                    found_id    <= low_id;
                    match_count <= sat_inc(match_count);
                    // Non-overlapping mode demands W fresh bits before the next match.
                    if (!overlap) begin
                        fill_cnt <= '0;
                        state    <= ST_FILL;
                    end else begin
                        fill_cnt <= FW'(W);
                        state    <= ST_SEARCH;
                    end
                end else if (state == ST_FILL) begin
                    if (fill_cnt == FW'(W - 1)) begin
                        fill_cnt <= FW'(W);
                        state    <= ST_SEARCH;
                    end else begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_multi.sv
// Directed bench for seq_detector_multi with a per-cycle reference model;
// build with SEQ_DET_MASK_EN to also exercise the masked slot case.
module tb_seq_detector_multi;

    localparam int W     = 8;
    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int IW    = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [W-1:0]     cfg_pattern;
    logic             cfg_en;
    logic [W-1:0]     cfg_mask;
    logic             start;
    logic             stop;
    logic             overlap;
    logic             bit_valid;
    logic             bit_in;
    logic             busy;
    logic             found;
    logic [N-1:0]     found_vec;
    logic [IW-1:0]    found_id;
    logic [CNT_W-1:0] match_count;

    int checks  = 0;
    int errors  = 0;
    int n_found = 0;
    bit chk_en  = 1'b0;

    seq_detector_multi #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_pattern (cfg_pattern),
        .cfg_en      (cfg_en),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask    (cfg_mask),
`endif
        .start       (start),
        .stop        (stop),
        .overlap     (overlap),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .busy        (busy),
        .found       (found),
        .found_vec   (found_vec),
        .found_id    (found_id),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: "active" flag, last W accepted bits, count of fresh bits.
    bit           m_act;
    bit [W-1:0]   m_hist;
    int           m_fresh;
    int           m_cnt;
    bit           e_found;
    bit [N-1:0]   e_vec;
    int           e_id;
    bit [W-1:0]   m_pat  [N];
    bit           m_en   [N];
    bit [W-1:0]   m_mask [N];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act = 0; m_hist = '0; m_fresh = 0; m_cnt = 0;
            e_found = 0; e_vec = '0; e_id = 0;
            for (int k = 0; k < N; k++) begin
                m_pat[k] = '0;
                m_en[k]  = 0;
`ifdef SEQ_DET_MASK_EN
                m_mask[k] = '0;
`else
                m_mask[k] = '1;
`endif
            end
        end else begin
            e_found = 0; e_vec = '0; e_id = 0;
            if (start) begin
                m_act = 1; m_hist = '0; m_fresh = 0; m_cnt = 0;
            end else if (stop) begin
                m_act = 0;
            end else if (m_act && bit_valid) begin
                m_hist = {m_hist[W-2:0], bit_in};
                m_fresh++;
                if (m_fresh >= W) begin
                    for (int k = 0; k < N; k++)
                        if (m_en[k] && (((m_hist ^ m_pat[k]) & m_mask[k]) == '0)) e_vec[k] = 1;
                    if (e_vec != '0) begin
                        e_found = 1;
                        for (int k = N - 1; k >= 0; k--) if (e_vec[k]) e_id = k;
                        if (m_cnt < MAXC) m_cnt++;
                        if (!overlap) m_fresh = 0;
                    end
                end
            end
            if (cfg_we && int'(cfg_idx) < N) begin
                m_pat[cfg_idx] = cfg_pattern;
                m_en[cfg_idx]  = cfg_en;
`ifdef SEQ_DET_MASK_EN
                m_mask[cfg_idx] = cfg_mask;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 64'(busy), 64'(m_act));
            check("found", 64'(found), 64'(e_found));
            check("found_vec", 64'(found_vec), 64'(e_vec));
            check("found_id", 64'(found_id), 64'(e_id));
            check("match_count", 64'(match_count), 64'(m_cnt));
            if (found) n_found++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input logic [W-1:0] pat, input logic en, input logic [W-1:0] msk);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_pattern = pat; cfg_en = en; cfg_mask = msk;
        step();
        cfg_we = 0;
    endtask

    task automatic go();
        start = 1;
        step();
        start = 0;
    endtask

    task automatic feed(input logic [511:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1; bit_in = v[i];
            step();
            bit_valid = 0;
        end
    endtask

    int base;

    initial begin
        rst_n = 0; cfg_we = 0; cfg_idx = '0; cfg_pattern = '0; cfg_en = 0; cfg_mask = '0;
        start = 0; stop = 0; overlap = 1; bit_valid = 0; bit_in = 0;
        step();
        chk_en = 1;
        step();
        rst_n = 1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset count", 64'(match_count), 64'd0);

        // Single slot, bit stream with idle gaps in the middle
        cfg(0, 8'hA5, 1, 8'hFF);
        go();
        feed(4'hA, 4);
        step(); step();
        feed(4'h5, 4);
        check("a5 found", 64'(found), 64'd1);
        check("a5 vec", 64'(found_vec), 64'h1);
        check("a5 id", 64'(found_id), 64'd0);
        check("a5 count", 64'(match_count), 64'd1);
        step();
        check("a5 pulse", 64'(found), 64'd0);

        // Overlapping vs non-overlapping on 1010101010
        cfg(1, 8'hAA, 1, 8'hFF);
        overlap = 1;
        go();
        base = n_found;
        feed(10'b1010101010, 10);
        step();
        check("ovl matches", 64'(n_found - base), 64'd2);
        check("ovl count", 64'(match_count), 64'd2);
        overlap = 0;
        go();
        base = n_found;
        feed(10'b1010101010, 10);
        step();
        check("novl matches", 64'(n_found - base), 64'd1);
        check("novl count", 64'(match_count), 64'd1);

        // Two slots matching together is one event
        cfg(0, 8'h0F, 1, 8'hFF);
        cfg(2, 8'h0F, 1, 8'hFF);
        go();
        feed(8'h0F, 8);
        check("multi vec", 64'(found_vec), 64'h5);
        check("multi id", 64'(found_id), 64'd0);
        check("multi count", 64'(match_count), 64'd1);

`ifdef SEQ_DET_MASK_EN
        cfg(0, 8'h00, 0, 8'hFF);
        cfg(1, 8'h00, 0, 8'hFF);
        cfg(2, 8'h00, 0, 8'hFF);
        cfg(3, 8'hF0, 1, 8'hF0);
        go();
        feed(8'hF6, 8);
        check("mask found", 64'(found), 64'd1);
        check("mask id", 64'(found_id), 64'd3);
        check("mask vec", 64'(found_vec), 64'h8);
        cfg(3, 8'hF0, 0, 8'hF0);
        go();
        base = n_found;
        feed(8'hF6, 8);
        step();
        check("mask disabled", 64'(n_found - base), 64'd0);
`endif

        // Saturation of the match counter
        cfg(0, 8'hFF, 1, 8'hFF);
        overlap = 1;
        go();
        for (int i = 0; i < 300; i++) feed(1'b1, 1);
        check("sat count", 64'(match_count), 64'd255);
        check("sat found", 64'(found), 64'd1);
        stop = 1;
        step();
        stop = 0;
        check("stop busy", 64'(busy), 64'd0);
        check("stop holds", 64'(match_count), 64'd255);
        base = n_found;
        feed(8'hFF, 8);
        step();
        check("idle ignores", 64'(n_found - base), 64'd0);

        // Reset in the middle of a matching pattern
        cfg(0, 8'hA5, 1, 8'hFF);
        go();
        base = n_found;
        feed(5'b10100, 5);
        rst_n = 0;
        step();
        rst_n = 1;
        feed(3'b101, 3);
        step();
        check("rst busy", 64'(busy), 64'd0);
        check("rst found", 64'(found), 64'd0);
        check("rst vec", 64'(found_vec), 64'd0);
        check("rst count", 64'(match_count), 64'd0);
        check("rst no match", 64'(n_found - base), 64'd0);

        // start wins over stop
        start = 1; stop = 1;
        step();
        start = 0; stop = 0;
        check("start>stop", 64'(busy), 64'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
